// File: rtl/evt2_fifo_decoder.sv
// EVT2 FIFO read side: pops words, decodes CD / TIME_HIGH, rebuilds the
// 34-bit timestamp and hands in-window CD events to the voxel binner.
module evt2_fifo_decoder #(
    parameter int SENSOR_W = 320,
    parameter int SENSOR_H = 320,
    parameter int X_BITS   = 9,
    parameter int Y_BITS   = 9,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fifo_empty,
    input  logic [31:0]         fifo_rd_data,
    output logic                fifo_rd_en,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [X_BITS-1:0]   ev_x,
    output logic [Y_BITS-1:0]   ev_y,
    output logic                ev_pol,
    output logic [33:0]         ev_ts,
    output logic                time_high_seen,
    output logic [CNT_BITS-1:0] cnt_events,
    output logic [CNT_BITS-1:0] cnt_dropped
);

    localparam logic [3:0] T_OFF = 4'h0;
    localparam logic [3:0] T_ON  = 4'h1;
    localparam logic [3:0] T_TH  = 4'h8;

    localparam logic [10:0] X_LIM = 11'(SENSOR_W);
    localparam logic [10:0] Y_LIM = 11'(SENSOR_H);

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        OUT
    } state_t;

    state_t state_q, state_d;

    logic                ev_valid_q, ev_valid_d;
    logic [X_BITS-1:0]   ev_x_q, ev_x_d;
    logic [Y_BITS-1:0]   ev_y_q, ev_y_d;
    logic                ev_pol_q, ev_pol_d;
    logic [33:0]         ev_ts_q, ev_ts_d;
    logic [27:0]         time_high_q, time_high_d;
    logic                th_seen_q, th_seen_d;
    logic [CNT_BITS-1:0] cnt_events_q, cnt_events_d;
    logic [CNT_BITS-1:0] cnt_dropped_q, cnt_dropped_d;

    logic [3:0]  w_type;
    logic [5:0]  w_ts;
    logic [10:0] w_x;
    logic [10:0] w_y;
    logic [27:0] w_th;
    logic        is_cd;
    logic        in_win;

    assign w_type = fifo_rd_data[31:28];
    assign w_ts   = fifo_rd_data[27:22];
    assign w_x    = fifo_rd_data[21:11];
    assign w_y    = fifo_rd_data[10:0];
    assign w_th   = fifo_rd_data[27:0];

    assign is_cd  = (w_type == T_OFF) || (w_type == T_ON);
    assign in_win = (w_x < X_LIM) && (w_y < Y_LIM);

    // Pop only when the result can be consumed; never rely on the FIFO guard.
    always_comb begin
        fifo_rd_en = !rst && !fifo_empty &&
                     ((state_q == IDLE) ||
                      ((state_q == OUT) && ev_ready));
    end

    always_comb begin
        state_d       = state_q;
        ev_valid_d    = ev_valid_q;
        ev_x_d        = ev_x_q;
        ev_y_d        = ev_y_q;
        ev_pol_d      = ev_pol_q;
        ev_ts_d       = ev_ts_q;
        time_high_d   = time_high_q;
        th_seen_d     = th_seen_q;
        cnt_events_d  = cnt_events_q;
        cnt_dropped_d = cnt_dropped_q;

        case (state_q)
            IDLE: begin
                if (fifo_rd_en) begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                state_d = IDLE;
                unique case (1'b1)
                    is_cd && in_win: begin
                        ev_x_d     = w_x[X_BITS-1:0];
                        ev_y_d     = w_y[Y_BITS-1:0];
                        ev_pol_d   = w_type[0];
                        ev_ts_d    = {time_high_q, w_ts};
                        ev_valid_d = 1'b1;
                        state_d    = OUT;
                    end
                    is_cd && !in_win: begin
                        if (cnt_dropped_q != CNT_MAX) begin
                            cnt_dropped_d = cnt_dropped_q + 1'b1;
                        end
                    end
                    w_type == T_TH: begin
                        time_high_d = w_th;
                        th_seen_d   = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end

            OUT: begin
                if (ev_ready) begin
                    ev_valid_d = 1'b0;
                    if (cnt_events_q != CNT_MAX) begin
                        cnt_events_d = cnt_events_q + 1'b1;
                    end
                    state_d = fifo_rd_en ? FETCH : IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ev_valid_q    <= 1'b0;
            ev_x_q        <= '0;
            ev_y_q        <= '0;
            ev_pol_q      <= 1'b0;
            ev_ts_q       <= '0;
            time_high_q   <= '0;
            th_seen_q     <= 1'b0;
            cnt_events_q  <= '0;
            cnt_dropped_q <= '0;
        end else begin
            state_q       <= state_d;
            ev_valid_q    <= ev_valid_d;
            ev_x_q        <= ev_x_d;
            ev_y_q        <= ev_y_d;
            ev_pol_q      <= ev_pol_d;
            ev_ts_q       <= ev_ts_d;
            time_high_q   <= time_high_d;
            th_seen_q     <= th_seen_d;
            cnt_events_q  <= cnt_events_d;
            cnt_dropped_q <= cnt_dropped_d;
        end
    end

    assign ev_valid       = ev_valid_q;
    assign ev_x           = ev_x_q;
    assign ev_y           = ev_y_q;
    assign ev_pol         = ev_pol_q;
    assign ev_ts          = ev_ts_q;
    assign time_high_seen = th_seen_q;
    assign cnt_events     = cnt_events_q;
    assign cnt_dropped    = cnt_dropped_q;

endmodule

// File: tb/tb_evt2_fifo_decoder.sv
// Bench for evt2_fifo_decoder: FIFO model plus an event-level reference
// model that decodes each pushed word straight from the EVT2 field rules.
module tb_evt2_fifo_decoder;

    localparam int CNT  = 4;
    localparam int CMAX = (1 << CNT) - 1;

    typedef struct {
        logic [8:0]  x;
        logic [8:0]  y;
        logic        pol;
        logic [33:0] ts;
    } ev_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           fifo_empty;
    logic [31:0]    fifo_rd_data;
    logic           fifo_rd_en;
    logic           ev_valid;
    logic           ev_ready;
    logic [8:0]     ev_x;
    logic [8:0]     ev_y;
    logic           ev_pol;
    logic [33:0]    ev_ts;
    logic           time_high_seen;
    logic [CNT-1:0] cnt_events;
    logic [CNT-1:0] cnt_dropped;

    evt2_fifo_decoder #(
        .SENSOR_W(320),
        .SENSOR_H(320),
        .X_BITS  (9),
        .Y_BITS  (9),
        .CNT_BITS(CNT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_empty    (fifo_empty),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_en    (fifo_rd_en),
        .ev_valid      (ev_valid),
        .ev_ready      (ev_ready),
        .ev_x          (ev_x),
        .ev_y          (ev_y),
        .ev_pol        (ev_pol),
        .ev_ts         (ev_ts),
        .time_high_seen(time_high_seen),
        .cnt_events    (cnt_events),
        .cnt_dropped   (cnt_dropped)
    );

    always #10 clk = ~clk;

    logic [31:0] fq[$];
    ev_t         exp_q[$];
    logic [27:0] m_th;
    logic        m_seen;
    int          m_drop;
    int          m_events;
    int          n_checks = 0;
    int          n_err    = 0;
    int          n_pops   = 0;
    logic        saw_valid;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        n_checks++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    function automatic logic [31:0] cd(input logic [3:0] t,
                                       input logic [5:0] ts,
                                       input logic [10:0] x,
                                       input logic [10:0] y);
        return {t, ts, x, y};
    endfunction

    task automatic reset_model();
        exp_q.delete();
        m_th     = '0;
        m_seen   = 1'b0;
        m_drop   = 0;
        m_events = 0;
    endtask

    // Word-level decode: in-order, so time_high applies to later words only.
    task automatic push(input logic [31:0] w);
        logic [3:0]  t;
        logic [10:0] x;
        logic [10:0] y;
        ev_t         e;
        fq.push_back(w);
        fifo_empty = 1'b0;
        t = w[31:28];
        x = w[21:11];
        y = w[10:0];
        if (t == 4'h8) begin
            m_th   = w[27:0];
            m_seen = 1'b1;
        end else if (t == 4'h0 || t == 4'h1) begin
            if (x < 11'd320 && y < 11'd320) begin
                e.x   = x[8:0];
                e.y   = y[8:0];
                e.pol = t[0];
                e.ts  = {m_th, w[27:22]};
                exp_q.push_back(e);
            end else begin
                m_drop = sat(m_drop);
            end
        end
    endtask

    task automatic tick();
        logic        pop, pv, pr, prst, pp;
        logic [8:0]  px, py;
        logic [33:0] pts;
        ev_t         e;
        #1;
        pop = fifo_rd_en;
        pv = ev_valid; pr = ev_ready; prst = rst;
        px = ev_x; py = ev_y; pp = ev_pol; pts = ev_ts;
        if (pop) n_pops++;
        if (ev_valid) saw_valid = 1'b1;
        chk("no_pop_when_empty", 64'(fifo_rd_en && fifo_empty), 64'(0));
        if (ev_valid && !ev_ready && !rst)
            chk("no_pop_stall", 64'(fifo_rd_en), 64'(0));
        if (ev_valid && ev_ready && !rst) begin
            chk("event_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("ev_x", 64'(ev_x), 64'(e.x));
                chk("ev_y", 64'(ev_y), 64'(e.y));
                chk("ev_pol", 64'(ev_pol), 64'(e.pol));
                chk("ev_ts", 64'(ev_ts), 64'(e.ts));
            end
            m_events = sat(m_events);
        end
        @(posedge clk);
        #1;
        if (rst) fq.delete();
        else if (pop && fq.size() != 0) fifo_rd_data = fq.pop_front();
        fifo_empty = (fq.size() == 0);
        @(negedge clk);
        if (pv && !pr && !prst && !rst) begin
            chk("hold_valid", 64'(ev_valid), 64'(1));
            chk("hold_x", 64'(ev_x), 64'(px));
            chk("hold_y", 64'(ev_y), 64'(py));
            chk("hold_pol", 64'(ev_pol), 64'(pp));
            chk("hold_ts", 64'(ev_ts), 64'(pts));
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        ev_ready = 1'b1;
        while (!(fq.size() == 0 && exp_q.size() == 0 && !ev_valid)
               && n < 400) begin
            tick();
            n++;
        end
        chk({tag, "_drain_timeout"}, 64'(n < 400), 64'(1));
        tick();
        tick();
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!ev_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid_timeout"}, 64'(ev_valid), 64'(1));
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_cnt_events"}, 64'(cnt_events), 64'(m_events));
        chk({tag, "_cnt_dropped"}, 64'(cnt_dropped), 64'(m_drop));
        chk({tag, "_th_seen"}, 64'(time_high_seen), 64'(m_seen));
    endtask

    function automatic logic [31:0] rand_word();
        int r;
        r = int'($urandom_range(0, 9));
        if (r <= 5) begin
            return cd((r <= 2) ? 4'h1 : 4'h0, 6'($urandom),
                      11'($urandom_range(0, 400)),
                      11'($urandom_range(0, 400)));
        end else if (r == 6) begin
            return {4'h8, 28'($urandom)};
        end else if (r == 7) begin
            return {4'hA, 28'($urandom)};
        end else if (r == 8) begin
            return {4'hE, 28'($urandom)};
        end
        return {4'hF, 28'($urandom)};
    endfunction

    function automatic logic [31:0] rand_in_win();
        return cd(4'($urandom_range(0, 1)), 6'($urandom),
                  11'($urandom_range(0, 319)),
                  11'($urandom_range(0, 319)));
    endfunction

    initial begin
        int p0;
        rst = 1'b1;
        ev_ready = 1'b0;
        fifo_empty = 1'b1;
        fifo_rd_data = '0;
        saw_valid = 1'b0;
        reset_model();

        // reset values
        @(negedge clk);
        tick();
        tick();
        chk("rst_valid", 64'(ev_valid), 64'(0));
        chk("rst_x", 64'(ev_x), 64'(0));
        chk("rst_y", 64'(ev_y), 64'(0));
        chk("rst_pol", 64'(ev_pol), 64'(0));
        chk("rst_ts", 64'(ev_ts), 64'(0));
        chk_counters("rst");
        push(32'h0000_0000);
        #1;
        chk("rst_no_pop", 64'(fifo_rd_en), 64'(0));
        tick();
        rst = 1'b0;
        reset_model();

        // CD_OFF before any TIME_HIGH, with pop-to-valid latency
        push(32'h0000_0000);
        #1;
        chk("lat0_pop", 64'(fifo_rd_en), 64'(1));
        tick();
        chk("lat0_fetch", 64'(ev_valid), 64'(0));
        tick();
        chk("lat0_valid", 64'(ev_valid), 64'(1));
        chk("cd0_ts", 64'(ev_ts), 64'(0));
        chk("cd0_th_seen", 64'(time_high_seen), 64'(0));
        drain("cd0");
        chk_counters("cd0");

        // TIME_HIGH then out-of-window x=401
        saw_valid = 1'b0;
        push(32'h8000_0005);
        push(cd(4'h1, 6'h29, 11'd401, 11'd100));
        drain("th");
        chk("th_no_valid", 64'(saw_valid), 64'(0));
        chk_counters("th");

        // x=321 dropped, then x=160 emitted with the new time_high
        push(cd(4'h1, 6'h28, 11'd321, 11'd100));
        drain("x321");
        chk_counters("x321");
        ev_ready = 1'b0;
        push(cd(4'h1, 6'h28, 11'd160, 11'd100));
        #1;
        chk("lat1_pop", 64'(fifo_rd_en), 64'(1));
        tick();
        chk("lat1_fetch", 64'(ev_valid), 64'(0));
        tick();
        chk("lat1_valid", 64'(ev_valid), 64'(1));
        chk("ev160_x", 64'(ev_x), 64'(160));
        chk("ev160_y", 64'(ev_y), 64'(100));
        chk("ev160_pol", 64'(ev_pol), 64'(1));
        chk("ev160_ts", 64'(ev_ts), 64'h168);
        drain("ev160");
        chk_counters("ev160");

        // window edges
        push(cd(4'h0, 6'h3, 11'd319, 11'd319));
        push(cd(4'h1, 6'h3, 11'd320, 11'd0));
        push(cd(4'h0, 6'h3, 11'd0, 11'd320));
        push(cd(4'h1, 6'h3, 11'd319, 11'd0));
        drain("edge");
        chk_counters("edge");

        // back-to-back: one pop every second cycle
        ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(rand_in_win());
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("b2b_pop", 64'(fifo_rd_en), 64'(i % 2 == 0));
            tick();
        end
        drain("b2b");
        chk_counters("b2b");

        // downstream stall
        ev_ready = 1'b0;
        push(rand_in_win());
        push(rand_in_win());
        wait_valid("stall");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_no_pop", 64'(fifo_rd_en), 64'(0));
        end
        drain("stall");
        chk_counters("stall");

        // ignored types, then an empty FIFO
        saw_valid = 1'b0;
        p0 = n_pops;
        push({4'hA, 28'h123_4567});
        push({4'hE, 28'hFFF_FFFF});
        drain("other");
        chk("other_pops", 64'(n_pops - p0), 64'(2));
        chk("other_no_valid", 64'(saw_valid), 64'(0));
        chk_counters("other");
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("empty_no_pop", 64'(fifo_rd_en), 64'(0));
        end

        // saturation of both counters
        for (int i = 0; i < 20; i++)
            push(cd(4'h1, 6'h0, 11'd2047, 11'($urandom_range(0, 2047))));
        for (int i = 0; i < 20; i++) push(rand_in_win());
        drain("sat");
        chk("sat_dropped", 64'(cnt_dropped), 64'(CMAX));
        chk("sat_events", 64'(cnt_events), 64'(CMAX));
        chk_counters("sat");

        // reset while an event is pending
        ev_ready = 1'b0;
        push(rand_in_win());
        wait_valid("mid");
        rst = 1'b1;
        push(rand_in_win());
        #1;
        chk("mid_rst_no_pop", 64'(fifo_rd_en), 64'(0));
        tick();
        rst = 1'b0;
        reset_model();
        chk("mid_valid", 64'(ev_valid), 64'(0));
        chk("mid_ts", 64'(ev_ts), 64'(0));
        chk_counters("mid");
        push(rand_in_win());
        #1;
        chk("mid_idle_pop", 64'(fifo_rd_en), 64'(1));
        tick();
        tick();
        chk("mid_after_valid", 64'(ev_valid), 64'(1));
        drain("mid");
        chk_counters("mid_after");

        // random traffic against the reference model
        for (int i = 0; i < 120; i++) begin
            ev_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 2) != 0) push(rand_word());
            tick();
        end
        drain("rand");
        chk_counters("rand");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
